// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if
//  Bundles the IF requester, DM requester and memory-side signals of the
//  unified memory arbiter.
//  Modports:
//   slave  - the arbiter's view: requests and memory responses in,
//            grants, responses and memory commands out.
//   master - the surrounding core/memory view (the mirror image).
//  Signals:
//   if_req/if_addr            IF read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata IF grant pulse, response pulse, read data
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be  DM request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata DM grant pulse, response pulse, read data
//   bus_err                   timeout flag, coincident with owner rvalid
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  memory command
//   mem_rvalid/mem_rdata      memory response
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            dm_req;
  logic            dm_we;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW/8-1:0] dm_be;
  logic            dm_gnt;
  logic            dm_rvalid;
  logic [DW-1:0]   dm_rdata;
  logic            bus_err;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata, bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//  Shares one single-port memory between instruction fetch (IF) and data
//  memory (DM). One transaction outstanding; DM has priority, but after
//  STARVE_MAX consecutive contended IF losses IF is forced to win. A BUSY
//  wait longer than TIMEOUT cycles ends with a bus error instead of a hang.
//  Ports:
//   clk   - clock, rising edge
//   srst  - synchronous reset, active low
//   bus   - unified_mem_arbiter_if.slave (requesters + memory)
//   perf_conflicts[31:0], perf_timeouts[15:0] - only with ARB_PERF_CNT_EN
//  Optional feature macro: ARB_PERF_CNT_EN (performance counters).
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 srst,
  unified_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_conflicts,
  output logic [15:0]          perf_timeouts
`endif
);
  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_reg, state_next;
  logic           owner_dm_reg;
  logic           err_reg;
  logic [SW-1:0]  starve_reg, starve_next;
  logic [TW-1:0]  tmo_reg;
  logic           we_reg;
  logic [AW-1:0]  addr_reg;
  logic [DW-1:0]  wdata_reg;
  logic [BW-1:0]  be_reg;
  logic [DW-1:0]  if_rdata_reg, dm_rdata_reg;

  logic           arb_en, contended, if_win, dm_win, grant;
  logic           resp_ok, resp_tmo;
  logic           mem_we_c;
  logic [AW-1:0]  mem_addr_c;
  logic [DW-1:0]  mem_wdata_c;
  logic [BW-1:0]  mem_be_c;

  // Arbitration happens in IDLE and in the RESP cycle; it is held off while
  // reset is asserted so no grant escapes during reset.
  always_comb begin
    arb_en    = srst && (state_reg == IDLE || state_reg == RESP);
    contended = arb_en && bus.if_req && bus.dm_req;
    if_win    = arb_en && bus.if_req && (!bus.dm_req || starve_reg == STARVE_TOP);
    dm_win    = arb_en && bus.dm_req && !if_win;
    grant     = if_win || dm_win;
  end

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    resp_ok     = 1'b0;
    resp_tmo    = 1'b0;
    case (state_reg)
      IDLE: if (grant) state_next = BUSY;
      BUSY: begin
        if (bus.mem_rvalid) begin
          resp_ok    = 1'b1;
          state_next = RESP;
        end else if (tmo_reg == TMO_LAST) begin
          resp_tmo   = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = grant ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
    if (if_win)
      starve_next = '0;
    else if (dm_win && contended && starve_reg != STARVE_TOP)
      starve_next = starve_reg + 1'b1;
  end

  // Memory command: the winner drives it in its grant cycle, otherwise the
  // last issued command is held.
  always_comb begin
    mem_we_c    = dm_win ? bus.dm_we    : (if_win ? 1'b0 : we_reg);
    mem_addr_c  = dm_win ? bus.dm_addr  : (if_win ? bus.if_addr : addr_reg);
    mem_wdata_c = dm_win ? bus.dm_wdata : (if_win ? '0 : wdata_reg);
  end

  // IF fetches always enable every byte lane.
  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_be
      assign mem_be_c[gi] = if_win ? 1'b1 : (dm_win ? bus.dm_be[gi] : be_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!srst) begin
      state_reg    <= IDLE;
      owner_dm_reg <= 1'b0;
      err_reg      <= 1'b0;
      starve_reg   <= '0;
      tmo_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      be_reg       <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      if (grant) begin
        owner_dm_reg <= dm_win;
        we_reg       <= mem_we_c;
        addr_reg     <= mem_addr_c;
        wdata_reg    <= mem_wdata_c;
        be_reg       <= mem_be_c;
        tmo_reg      <= '0;
      end else if (state_reg == BUSY) begin
        tmo_reg <= tmo_reg + 1'b1;
      end
      if (resp_ok) begin
        err_reg <= 1'b0;
        if (owner_dm_reg) dm_rdata_reg <= we_reg ? '0 : bus.mem_rdata;
        else              if_rdata_reg <= bus.mem_rdata;
      end
      if (resp_tmo) begin
        err_reg <= 1'b1;
        if (owner_dm_reg) dm_rdata_reg <= '0;
        else              if_rdata_reg <= '0;
      end
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.if_rvalid = srst && state_reg == RESP && !owner_dm_reg;
  assign bus.dm_rvalid = srst && state_reg == RESP && owner_dm_reg;
  assign bus.bus_err   = srst && state_reg == RESP && err_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.mem_req   = grant;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_be    = mem_be_c;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflicts_reg;
  logic [15:0] perf_timeouts_reg;

  always_ff @(posedge clk) begin
    if (!srst) begin
      perf_conflicts_reg <= '0;
      perf_timeouts_reg  <= '0;
    end else begin
      if (contended) perf_conflicts_reg <= perf_conflicts_reg + 1'b1;
      if (resp_tmo)  perf_timeouts_reg  <= perf_timeouts_reg + 1'b1;
    end
  end

  assign perf_conflicts = perf_conflicts_reg;
  assign perf_timeouts  = perf_timeouts_reg;
`endif
endmodule
